// File: rtl/irq_pkg.sv
// Shared types and helpers for the interrupt request unit: FSM state encoding,
// default sizing and the lowest-index-wins priority encoder.
package irq_pkg;

   localparam int NUM_IRQ_DEF = 8;
   localparam int VEC_W_DEF   = 3;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      INT_REQ = 2'd1,
      NMI_REQ = 2'd2,
      SERVICE = 2'd3
   } irq_state_t;

   function automatic logic [4:0] prio_enc(input logic [31:0] v);
      logic [4:0] r;
      r = '0;
      for (int i = 31; i >= 0; i--) begin
         if (v[i]) r = 5'(i);
      end
      return r;
   endfunction

endpackage

// File: rtl/interrupt_request_unit_if.sv
// Processor-side handshake of the interrupt request unit: INT/NMI requests,
// INA acknowledge, EOI and the in-service vector/status.
interface interrupt_request_unit_if #(parameter int VEC_W = irq_pkg::VEC_W_DEF);

   logic             int_o;
   logic             nmi_o;
   logic             ina;
   logic             eoi;
   logic [VEC_W-1:0] vec_o;
   logic             vec_valid;
   logic             nmi_active;

   modport master (
      output int_o, nmi_o, vec_o, vec_valid, nmi_active,
      input  ina, eoi
   );

   modport slave (
      input  int_o, nmi_o, vec_o, vec_valid, nmi_active,
      output ina, eoi
   );

endinterface

// File: rtl/irq_edge_detect.sv
// Per-bit rising-edge pulse generator. With IRQ_SYNC_EN defined each input first
// passes through a two-flop synchronizer; otherwise inputs are taken as synchronous.
module irq_edge_detect #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] rise
);

   logic [WIDTH-1:0] sync;
   logic [WIDTH-1:0] hist;

`ifdef IRQ_SYNC_EN
   logic [WIDTH-1:0] sync_q1;
   logic [WIDTH-1:0] sync_q2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q1 <= '0;
         sync_q2 <= '0;
      end else begin
         sync_q1 <= din;
         sync_q2 <= sync_q1;
      end
   end

   assign sync = sync_q2;
`else
   assign sync = din;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) hist <= '0;
      else        hist <= sync;
   end

   assign rise = sync & ~hist;

endmodule

// File: rtl/interrupt_request_unit.sv
// Interrupt request unit: edge-triggered pending capture, masking, fixed priority,
// NMI preemption and EOI tracking in front of the processor. Optional IRQ_SYNC_EN.
//
// state   | meaning
// IDLE    | nothing requested or in service
// INT_REQ | int_o raised, waiting for ina on a maskable request
// NMI_REQ | nmi_o raised, waiting for ina
// SERVICE | handler running; wait for eoi (NMI may nest over a maskable handler)
module interrupt_request_unit
   import irq_pkg::*;
#(
   parameter int                 NUM_IRQ  = NUM_IRQ_DEF,
   parameter int                 VEC_W    = VEC_W_DEF,
   parameter logic [NUM_IRQ-1:0] MASK_RST = '1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_IRQ-1:0]   irq_i,
   input  logic                 nmi_i,
   input  logic                 mask_we,
   input  logic [NUM_IRQ-1:0]   mask_d,
   output logic [NUM_IRQ-1:0]   pending_o,
   interrupt_request_unit_if.master cpu
);

   irq_state_t         state, state_nxt;
   logic [NUM_IRQ-1:0] pending, mask, irq_rise, eligible, clr_sel, clr;
   logic               nmi_rise, nmi_pend;
   logic               vec_valid, nmi_active, vv_nxt, na_nxt;
   logic               ack_int, ack_nmi;
   logic               int_q, nmi_q;
   logic [VEC_W-1:0]   vec;
   logic [4:0]         winner;

   irq_edge_detect #(.WIDTH(NUM_IRQ)) u_irq_ed (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (irq_i),
      .rise (irq_rise)
   );

   irq_edge_detect #(.WIDTH(1)) u_nmi_ed (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (nmi_i),
      .rise (nmi_rise)
   );

   assign eligible = pending & ~mask;
   assign winner   = prio_enc(32'(eligible));
   assign clr_sel  = NUM_IRQ'(1) << winner;
   assign clr      = ack_int ? clr_sel : '0;

   always_comb begin
      state_nxt = state;
      ack_int   = 1'b0;
      ack_nmi   = 1'b0;
      na_nxt    = nmi_active;
      vv_nxt    = vec_valid;

      // eoi retires the innermost handler; an NMI is always the innermost one
      if (cpu.eoi) begin
         if (nmi_active)     na_nxt = 1'b0;
         else if (vec_valid) vv_nxt = 1'b0;
      end

      case (state)
         IDLE: begin
            if (nmi_pend && !nmi_active)       state_nxt = NMI_REQ;
            else if (|eligible && !vec_valid)  state_nxt = INT_REQ;
         end
         INT_REQ: begin
            if (nmi_pend)            state_nxt = NMI_REQ;
            else if (~|eligible)     state_nxt = IDLE;
            else if (cpu.ina) begin
               ack_int   = 1'b1;
               state_nxt = SERVICE;
            end
         end
         NMI_REQ: begin
            if (cpu.ina) begin
               ack_nmi   = 1'b1;
               state_nxt = SERVICE;
            end
         end
         SERVICE: begin
            if (nmi_pend && !nmi_active) state_nxt = NMI_REQ;
            else if (!vv_nxt && !na_nxt) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase

      if (ack_int) vv_nxt = 1'b1;
      if (ack_nmi) na_nxt = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         pending    <= '0;
         nmi_pend   <= 1'b0;
         mask       <= MASK_RST;
         vec        <= '0;
         vec_valid  <= 1'b0;
         nmi_active <= 1'b0;
         int_q      <= 1'b0;
         nmi_q      <= 1'b0;
      end else begin
         state      <= state_nxt;
         // a fresh edge on a line being acknowledged keeps it pending
         pending    <= (pending & ~clr) | irq_rise;
         nmi_pend   <= (nmi_pend & ~ack_nmi) | nmi_rise;
         if (mask_we) mask <= mask_d;
         if (ack_int) vec  <= VEC_W'(winner);
         vec_valid  <= vv_nxt;
         nmi_active <= na_nxt;
         int_q      <= (state_nxt == INT_REQ);
         nmi_q      <= (state_nxt == NMI_REQ);
      end
   end

   assign cpu.int_o      = int_q;
   assign cpu.nmi_o      = nmi_q;
   assign cpu.vec_o      = vec;
   assign cpu.vec_valid  = vec_valid;
   assign cpu.nmi_active = nmi_active;
   assign pending_o      = pending;

endmodule

// File: tb/tb_interrupt_request_unit.sv
// Bench for interrupt_request_unit: directed scenarios plus randomized traffic,
// all cycles compared against a request/service-stack reference model.
module tb_interrupt_request_unit;

   localparam int N  = 8;
   localparam int VW = 3;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [N-1:0] irq_i = '0;
   logic         nmi_i = 1'b0;
   logic         mask_we = 1'b0;
   logic [N-1:0] mask_d = '0;
   logic [N-1:0] pending_o;

   interrupt_request_unit_if #(.VEC_W(VW)) cpu ();

   interrupt_request_unit #(.NUM_IRQ(N), .VEC_W(VW), .MASK_RST('1)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .irq_i    (irq_i),
      .nmi_i    (nmi_i),
      .mask_we  (mask_we),
      .mask_d   (mask_d),
      .pending_o(pending_o),
      .cpu      (cpu.master)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // reference model: m_req 0=none 1=INT 2=NMI; m_stack holds handlers in service (1=NMI)
   bit [N-1:0]  m_pend, m_mask, m_prev;
   bit          m_npend, m_nprev;
   int          m_req;
   bit          m_stack[$];
   bit [VW-1:0] m_vec;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic bit stack_has(input bit kind);
      bit r = 1'b0;
      foreach (m_stack[i]) if (m_stack[i] == kind) r = 1'b1;
      return r;
   endfunction

   task automatic model_reset();
      m_pend = '0; m_mask = '1; m_prev = '0;
      m_npend = 1'b0; m_nprev = 1'b0;
      m_req = 0; m_vec = '0;
      m_stack.delete();
   endtask

   task automatic model_step();
      bit [N-1:0] rise, elig, clr;
      bit         nrise, nclr, has_n, was_idle;
      int         win;
      rise = irq_i & ~m_prev;
      nrise = nmi_i & ~m_nprev;
      m_prev = irq_i;
      m_nprev = nmi_i;
      elig = m_pend & ~m_mask;
      win = -1;
      for (int i = N - 1; i >= 0; i--) if (elig[i]) win = i;
      clr = '0;
      nclr = 1'b0;
      has_n = stack_has(1'b1);
      was_idle = (m_stack.size() == 0);
      if (cpu.eoi && m_stack.size() > 0) void'(m_stack.pop_back());
      case (m_req)
         1: begin
            if (m_npend) m_req = 2;
            else if (win < 0) m_req = 0;
            else if (cpu.ina) begin
               m_vec = win[VW-1:0];
               clr[win] = 1'b1;
               m_stack.push_back(1'b0);
               m_req = 0;
            end
         end
         2: begin
            if (cpu.ina) begin
               nclr = 1'b1;
               m_stack.push_back(1'b1);
               m_req = 0;
            end
         end
         default: begin
            if (was_idle) begin
               if (m_npend) m_req = 2;
               else if (win >= 0) m_req = 1;
            end else if (m_npend && !has_n) begin
               m_req = 2;
            end
         end
      endcase
      m_pend = (m_pend & ~clr) | rise;
      m_npend = (m_npend & ~nclr) | nrise;
      if (mask_we) m_mask = mask_d;
   endtask

   task automatic check_outputs();
      chk("int_o",      32'(cpu.int_o),      32'(m_req == 1));
      chk("nmi_o",      32'(cpu.nmi_o),      32'(m_req == 2));
      chk("vec_o",      32'(cpu.vec_o),      32'(m_vec));
      chk("vec_valid",  32'(cpu.vec_valid),  32'(stack_has(1'b0)));
      chk("nmi_active", 32'(cpu.nmi_active), 32'(stack_has(1'b1)));
      chk("pending_o",  32'(pending_o),      32'(m_pend));
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_outputs();
   endtask

   task automatic pulse_irq(input logic [N-1:0] v);
      irq_i = v;
      cycle();
      irq_i = '0;
      cycle();
   endtask

   task automatic pulse_nmi();
      nmi_i = 1'b1;
      cycle();
      nmi_i = 1'b0;
      cycle();
   endtask

   task automatic write_mask(input logic [N-1:0] v);
      mask_we = 1'b1;
      mask_d = v;
      cycle();
      mask_we = 1'b0;
   endtask

   task automatic ack();
      cpu.ina = 1'b1;
      cycle();
      cpu.ina = 1'b0;
   endtask

   task automatic end_irq();
      cpu.eoi = 1'b1;
      cycle();
      cpu.eoi = 1'b0;
   endtask

   initial begin
      cpu.ina = 1'b0;
      cpu.eoi = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      chk("rst int_o", 32'(cpu.int_o), 32'd0);
      chk("rst nmi_o", 32'(cpu.nmi_o), 32'd0);
      chk("rst vec_o", 32'(cpu.vec_o), 32'd0);
      chk("rst pending", 32'(pending_o), 32'd0);
      rst_n = 1'b1;

      // single line, two-cycle request latency then acknowledge
      write_mask(8'h00);
      irq_i = 8'h20;
      cycle();
      irq_i = 8'h00;
      chk("t1 int_o before", 32'(cpu.int_o), 32'd0);
      cycle();
      chk("t1 int_o", 32'(cpu.int_o), 32'd1);
      ack();
      chk("t1 vec_o", 32'(cpu.vec_o), 32'd5);
      chk("t1 vec_valid", 32'(cpu.vec_valid), 32'd1);
      chk("t1 pending", 32'(pending_o), 32'h00);
      chk("t1 int_o after", 32'(cpu.int_o), 32'd0);
      end_irq();
      cycle();

      // simultaneous edges: lowest index served first
      pulse_irq(8'h44);
      ack();
      chk("t2 vec first", 32'(cpu.vec_o), 32'd2);
      end_irq();
      cycle();
      chk("t2 int_o again", 32'(cpu.int_o), 32'd1);
      ack();
      chk("t2 vec second", 32'(cpu.vec_o), 32'd6);
      end_irq();
      cycle();

      // masked line stays pending, unmask releases it
      write_mask(8'hFF);
      pulse_irq(8'h08);
      cycle();
      chk("t3 int_o masked", 32'(cpu.int_o), 32'd0);
      chk("t3 pending", 32'(pending_o), 32'h08);
      write_mask(8'h00);
      cycle();
      chk("t3 int_o unmasked", 32'(cpu.int_o), 32'd1);

      // NMI preempts an unacknowledged maskable request
      pulse_nmi();
      chk("t4 int_o", 32'(cpu.int_o), 32'd0);
      chk("t4 nmi_o", 32'(cpu.nmi_o), 32'd1);
      ack();
      chk("t4 nmi_active", 32'(cpu.nmi_active), 32'd1);
      chk("t4 pending kept", 32'(pending_o), 32'h08);
      end_irq();
      cycle();
      ack();
      chk("t4 vec", 32'(cpu.vec_o), 32'd3);
      end_irq();
      cycle();

      // NMI nests over a maskable handler
      pulse_irq(8'h10);
      ack();
      chk("t5 vec", 32'(cpu.vec_o), 32'd4);
      pulse_nmi();
      chk("t5 nmi_o", 32'(cpu.nmi_o), 32'd1);
      ack();
      chk("t5 nmi_active", 32'(cpu.nmi_active), 32'd1);
      chk("t5 vec_valid", 32'(cpu.vec_valid), 32'd1);
      end_irq();
      chk("t5 eoi1 nmi_active", 32'(cpu.nmi_active), 32'd0);
      chk("t5 eoi1 vec_valid", 32'(cpu.vec_valid), 32'd1);
      end_irq();
      chk("t5 eoi2 vec_valid", 32'(cpu.vec_valid), 32'd0);
      cycle();
      chk("t5 idle int_o", 32'(cpu.int_o), 32'd0);

      // asynchronous reset mid-request
      pulse_irq(8'h01);
      chk("t6 int_o", 32'(cpu.int_o), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6 rst int_o", 32'(cpu.int_o), 32'd0);
      chk("t6 rst nmi_o", 32'(cpu.nmi_o), 32'd0);
      chk("t6 rst vec_valid", 32'(cpu.vec_valid), 32'd0);
      chk("t6 rst pending", 32'(pending_o), 32'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      pulse_irq(8'h80);
      cycle();
      chk("t6 mask reset int_o", 32'(cpu.int_o), 32'd0);
      chk("t6 mask reset pending", 32'(pending_o), 32'h80);
      write_mask(8'h00);

      // randomized traffic
      for (int k = 0; k < 3000; k++) begin
         irq_i   = N'($urandom & $urandom & $urandom);
         nmi_i   = ($urandom_range(0, 11) == 0);
         mask_we = ($urandom_range(0, 15) == 0);
         mask_d  = N'($urandom & $urandom);
         cpu.ina = (m_req != 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
         cpu.eoi = (m_stack.size() > 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
         cycle();
         chk("rnd exclusive", 32'(cpu.int_o & cpu.nmi_o), 32'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/interrupt_request_unit.md
Name: interrupt_request_unit

Overview:
- Sits directly upstream of the multi-cycle processor's controller. Collects device interrupt lines and a non-maskable source, and drives the processor's INT/NMI request inputs.
- Consumes the processor's INA acknowledge, then presents the serviced interrupt's vector.
- Provides per-line masking, fixed priority (lowest index wins), NMI preemption and end-of-interrupt (EOI) tracking.

Parameters:
- NUM_IRQ, 8, number of maskable device lines (2..32).
- VEC_W, 3, vector width; must satisfy 2**VEC_W >= NUM_IRQ.
- MASK_RST, all ones, reset value of the mask register (1 = masked).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- irq_i  in  NUM_IRQ  device request lines, rising-edge triggered.
- nmi_i  in  1  non-maskable request, rising-edge triggered.
- mask_we  in  1  write strobe for the mask register.
- mask_d  in  NUM_IRQ  mask write data.
- eoi  in  1  one-cycle end-of-interrupt pulse from the handler.
- ina  in  1  interrupt acknowledge from the processor.
- int_o  out  1  maskable request to the processor (INT).
- nmi_o  out  1  non-maskable request to the processor (NMI).
- vec_o  out  VEC_W  index of the acknowledged maskable line.
- vec_valid  out  1  a maskable interrupt is in service.
- nmi_active  out  1  an NMI is in service.
- pending_o  out  NUM_IRQ  raw pending bits, for debug and status.

Behaviour:
- Reset (async assert, sync release): state=IDLE; pending=0; nmi_pend=0; mask=MASK_RST; int_o=0; nmi_o=0; vec_o=0; vec_valid=0; nmi_active=0; edge-detect history regs=0.
- Edge detect:
  - pending[i] sets one cycle after irq_i[i] goes 0->1; nmi_pend likewise from nmi_i.
  - A level held high does not re-trigger.
- Mask:
  - mask_we loads mask_d at the clock edge, effective the next cycle.
  - Masking never clears pending bits.
- eligible = pending & ~mask. Winner = lowest set index of eligible.
- FSM state IDLE:
  - nmi_pend and !nmi_active -> NMI_REQ.
  - Else eligible!=0 and !vec_valid -> INT_REQ.
- FSM state INT_REQ, int_o=1 (registered output):
  - nmi_pend -> NMI_REQ; int_o drops the same cycle, NMI preempts before acknowledge.
  - Else ina=1: vec_o=winner, clear pending[winner], vec_valid=1 -> SERVICE.
  - Else eligible==0 (mask write removed the request) -> IDLE.
- FSM state NMI_REQ, nmi_o=1:
  - ina=1: clear nmi_pend, nmi_active=1 -> SERVICE.
- FSM state SERVICE:
  - nmi_pend and !nmi_active -> NMI_REQ (nests over a maskable handler).
  - eoi clears nmi_active if set, otherwise clears vec_valid.
  - When both flags are clear after eoi -> IDLE.
  - No maskable nesting: a new maskable request waits for IDLE.
- Request latency: edge at cycle N -> pending at N+1 -> int_o/nmi_o high at N+2.
- ina is ignored outside INT_REQ/NMI_REQ.
- eoi with both flags clear is ignored.
- A new edge on the line being cleared in the same cycle: set wins, pending stays 1.
- vec_o holds its value until the next acknowledge.
- Reset mid-handshake: immediate return to reset values; in-flight requests are lost.
- int_o and nmi_o are never high together.

Optional Feature:
- Macro IRQ_SYNC_EN.
- Defined: irq_i and nmi_i each pass through a two-flop synchronizer (reset to 0) before edge detection. Request latency becomes N+4.
- Undefined: inputs are assumed synchronous to clk, no synchronizer, latency N+2.

Decomposition:
- Shared package (irq_pkg):
  - FSM state enum IDLE/INT_REQ/NMI_REQ/SERVICE.
  - Default NUM_IRQ and VEC_W constants.
  - Priority-encode function.
- One natural sub-module, irq_edge_detect: per-bit optional synchronizer plus rising-edge pulse generator, parameterised by width. Instantiated once for irq_i and once for nmi_i.

Test Plan:
- Reset with irq_i=8'h00, then pulse irq_i[5] with mask=8'h00 -> int_o=1 two cycles later. On ina: vec_o=5, vec_valid=1, pending_o=8'h00, int_o=0.
- Edges on irq_i[6] and irq_i[2] in the same cycle, mask=8'h00 -> first acknowledge gives vec_o=2. After eoi, int_o rises again and the second acknowledge gives vec_o=6.
- Edge on irq_i[3] with mask=8'hFF -> int_o stays 0 and pending_o=8'h08. Writing mask=8'h00 -> int_o=1 two cycles later.
- In INT_REQ, pulse nmi_i before ina -> int_o=0, nmi_o=1. On ina: nmi_active=1, and the maskable request stays pending.
- In SERVICE with vec_o=4, pulse nmi_i -> nmi_o=1. On ina, nmi_active=1. First eoi clears nmi_active only; second eoi clears vec_valid and the FSM returns to IDLE.
- Assert rst_n=0 asynchronously while int_o=1 -> all outputs 0 without a clock edge, and mask reads back all ones.
